// File: rtl/plugin_issue_ctrl_if.sv
// Handshake bundle between the execute stage, plugin accelerator and writeback
// for plugin_issue_ctrl. The controller uses the slave modport.
interface plugin_issue_ctrl_if #(
  parameter int unsigned LAT_W = 16
);
  logic             issue_valid;
  logic [31:0]      issue_rs1;
  logic [31:0]      issue_rs2;
  logic [4:0]       issue_rd;
  logic             flush;
  logic             stall;
  logic             plugin_start;
  logic [31:0]      plugin_operand_a;
  logic [31:0]      plugin_operand_b;
  logic             plugin_busy;
  logic             plugin_done;
  logic [31:0]      plugin_result;
  logic             wb_valid;
  logic [31:0]      wb_data;
  logic [4:0]       wb_rd;
  logic [LAT_W-1:0] last_latency;
  logic             proto_err;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, flush,
    output plugin_busy, plugin_done, plugin_result,
    input  stall, plugin_start, plugin_operand_a, plugin_operand_b,
    input  wb_valid, wb_data, wb_rd, last_latency, proto_err
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, flush,
    input  plugin_busy, plugin_done, plugin_result,
    output stall, plugin_start, plugin_operand_a, plugin_operand_b,
    output wb_valid, wb_data, wb_rd, last_latency, proto_err
  );
endinterface

// File: rtl/plugin_issue_ctrl.sv
// Issue/writeback controller for a start/busy/done plugin accelerator.
// Optional WAIT watchdog with orphan tracking is enabled by PLUGIN_TIMEOUT_EN.
module plugin_issue_ctrl #(
  parameter int unsigned LAT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  plugin_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("plugin_issue_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  state_t           state_q, state_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [31:0]      rs2_q, rs2_d;
  logic [4:0]       rd_q, rd_d;
  logic             kill_q, kill_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [LAT_W-1:0] last_lat_q, last_lat_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             proto_q, proto_d;
  logic [LAT_W-1:0] lat_inc;
  logic             done_counts;

`ifdef PLUGIN_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            orphan_q, orphan_d;
`endif

  assign lat_inc = (lat_q == '1) ? lat_q : lat_q + LAT_W'(1);

  always_comb begin
    state_d    = state_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    kill_d     = kill_q;
    lat_d      = lat_q;
    last_lat_d = last_lat_q;
    wb_data_d  = wb_data_q;
    proto_d    = proto_q;
    bus.stall        = 1'b0;
    bus.plugin_start = 1'b0;
    done_counts      = bus.plugin_done;
`ifdef PLUGIN_TIMEOUT_EN
    wdog_d   = wdog_q;
    orphan_d = orphan_q;
    // The first done after a timeout belongs to the abandoned op: swallow it.
    if (orphan_q && bus.plugin_done) begin
      orphan_d    = 1'b0;
      done_counts = 1'b0;
    end
`endif

    case (state_q)
      IDLE: begin
`ifdef PLUGIN_TIMEOUT_EN
        if (orphan_q) begin
          bus.stall = bus.issue_valid;
        end else
`endif
        if (bus.issue_valid && !bus.flush) begin
          bus.stall = 1'b1;
          rs1_d     = bus.issue_rs1;
          rs2_d     = bus.issue_rs2;
          rd_d      = bus.issue_rd;
          state_d   = ISSUE;
        end
        if (done_counts) proto_d = 1'b1;
      end

      ISSUE: begin
        bus.stall        = 1'b1;
        bus.plugin_start = 1'b1;
        lat_d            = '0;
        if (bus.flush) kill_d = 1'b1;
        if (done_counts) proto_d = 1'b1;
`ifdef PLUGIN_TIMEOUT_EN
        wdog_d = '0;
`endif
        state_d = WAIT;
      end

      WAIT: begin
        bus.stall = 1'b1;
        lat_d     = lat_inc;
        if (bus.flush) kill_d = 1'b1;
        if (done_counts) begin
          wb_data_d  = bus.plugin_result;
          last_lat_d = lat_inc;
          state_d    = RESP;
        end else begin
          if (!bus.plugin_busy) proto_d = 1'b1;
`ifdef PLUGIN_TIMEOUT_EN
          if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            wb_data_d = '1;
            proto_d   = 1'b1;
            orphan_d  = 1'b1;
            state_d   = RESP;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
`endif
        end
      end

      RESP: begin
        kill_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      kill_q     <= 1'b0;
      lat_q      <= '0;
      last_lat_q <= '0;
      wb_data_q  <= '0;
      proto_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      kill_q     <= kill_d;
      lat_q      <= lat_d;
      last_lat_q <= last_lat_d;
      wb_data_q  <= wb_data_d;
      proto_q    <= proto_d;
    end
  end

`ifdef PLUGIN_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q   <= '0;
      orphan_q <= 1'b0;
    end else begin
      wdog_q   <= wdog_d;
      orphan_q <= orphan_d;
    end
  end
`endif

  assign bus.plugin_operand_a = rs1_q;
  assign bus.plugin_operand_b = rs2_q;
  assign bus.wb_valid         = (state_q == RESP) && !kill_q;
  assign bus.wb_rd            = (state_q == RESP) ? rd_q : '0;
  assign bus.wb_data          = wb_data_q;
  assign bus.last_latency     = last_lat_q;
  assign bus.proto_err        = proto_q;

endmodule

// File: doc/plugin_issue_ctrl.md
Name: plugin_issue_ctrl

Overview:
- Issue/writeback controller between the RS5 execute stage and one start/busy/done plugin accelerator (e.g. the Fibonacci plugin).
- Accepts a decoded custom instruction and latches rs1/rs2/rd.
- Pulses the plugin start, stalls the pipeline until the plugin reports done, then presents the result to writeback for exactly one cycle.
- Also tracks per-op latency and flags protocol violations.

Parameters:
- LAT_W, 16, width of the saturating latency counter.
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  execute stage holds a plugin instruction.
- issue_rs1  in  32  operand A.
- issue_rs2  in  32  operand B.
- issue_rd  in  5  destination register.
- flush  in  1  pipeline flush; kills the in-flight op.
- stall  out  1  freeze upstream stages.
- plugin_start  out  1  one-cycle start pulse to the plugin.
- plugin_operand_a  out  32  latched rs1.
- plugin_operand_b  out  32  latched rs2.
- plugin_busy  in  1  plugin busy.
- plugin_done  in  1  plugin done pulse.
- plugin_result  in  32  plugin result, valid while plugin_done is high.
- wb_valid  out  1  result valid for writeback.
- wb_data  out  32  result.
- wb_rd  out  5  destination register.
- last_latency  out  LAT_W  cycles from start to done of the last completed op; saturating.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset: every output is 0; state is IDLE; kill flag, latches and counters are cleared. Reset mid-operation abandons the op silently; the plugin's own reset is separate.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If issue_valid && !flush at a clock edge: latch rs1, rs2, rd; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - plugin_start = 1 for exactly this one cycle; plugin_operand_a/b are stable from here until leaving WAIT.
  - Clear the latency counter; go to WAIT.
- WAIT:
  - Latency counter increments each cycle and saturates at all-ones.
  - When plugin_done is sampled high: capture plugin_result into wb_data; store counter+1 (saturating) into last_latency; go to RESP.
- RESP (exactly one cycle):
  - wb_valid = !kill; wb_rd = latched rd.
  - Then go to IDLE and clear kill.
- stall (combinational) = (IDLE && issue_valid && !flush) || ISSUE || WAIT. stall is low in RESP, so the pipeline advances together with the writeback.
- Latency: wb_valid rises 1 cycle after the edge at which plugin_done is sampled.
- Minimum issue-to-wb_valid is 3 cycles plus the plugin latency.
- A new issue is accepted only in IDLE. issue_valid during RESP is ignored and is taken the next cycle.
- flush:
  - In IDLE: blocks acceptance.
  - In ISSUE/WAIT: sets kill. The plugin cannot be aborted, so the controller still waits for done, then returns through RESP with wb_valid=0. last_latency is still updated.
  - In RESP: ignored; the op has already committed.
- Protocol check: proto_err is set if plugin_done is high in IDLE or ISSUE, or if plugin_busy is low for a full WAIT cycle without done. Such a done is otherwise ignored. proto_err clears only on reset.
- Widths: all data is 32-bit pass-through; no arithmetic on data. The latency counter is LAT_W bits and saturates, never wraps.

Optional Feature:
- Macro: PLUGIN_TIMEOUT_EN.
- Enabled:
  - A WAIT-cycle watchdog counts to TIMEOUT_CYCLES. On expiry: go to RESP with wb_data=32'hFFFF_FFFF, wb_valid=!kill, proto_err set, orphan flag set.
  - While orphan is set, IDLE does not accept issues (stall follows issue_valid). The next plugin_done clears orphan and is discarded without setting proto_err.
- Disabled: no watchdog; WAIT waits indefinitely; no orphan logic.

Test Plan:
- Reset 3 cycles, then idle → all outputs 0, stall 0.
- Issue rs1=10, rd=5 → plugin_start high exactly 1 cycle with operand_a=10. Done with result 55 → next cycle wb_valid=1, wb_data=55, wb_rd=5. stall low in that cycle. last_latency equals the start-to-done cycle count.
- Back-to-back issues rs1=0 then rs1=1 (issue_valid held) → two writebacks with 0 then 1; second start no earlier than the cycle after RESP.
- flush pulsed 2 cycles into WAIT for rs1=20 → done with 6765 produces no wb_valid. Controller returns to IDLE; a following issue of rs1=2 writes back 1.
- plugin_done asserted while IDLE → proto_err=1 and stays 1; no wb_valid. Only reset clears proto_err.
- With PLUGIN_TIMEOUT_EN and TIMEOUT_CYCLES=8, plugin never asserts done → after 8 WAIT cycles wb_data=FFFF_FFFF, wb_valid=1, proto_err=1. A new issue stalls until a late done arrives, then is accepted normally.
